// File: rtl/intersection_phase_arbiter.sv
// Round-robin green-phase scheduler for an N-approach intersection with min/max green,
// yellow and all-red clearance. Optional emergency preemption under macro PREEMPT_EN.
module intersection_phase_arbiter #(
    parameter int N_APPR    = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int TW        = 4,
    localparam int IW       = (N_APPR > 1) ? $clog2(N_APPR) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_APPR-1:0]     req,
`ifdef PREEMPT_EN
    input  logic                  preempt,
    input  logic [IW-1:0]         preempt_idx,
`endif
    output logic [2*N_APPR-1:0]   lights,
    output logic [IW-1:0]         active_idx,
    output logic [1:0]            phase,
    output logic                  grant_pulse
);

    typedef enum logic [1:0] {
        ALLRED = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10
    } phase_t;

    localparam logic [TW-1:0] AR_LAST = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] GM_LAST = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GX_LAST = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] Y_LAST  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] T_SAT   = {TW{1'b1}};

    phase_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d, timer_inc;
    logic [IW-1:0]         active_q, active_d;
    logic                  grant_q, grant_d;
    logic [2*N_APPR-1:0]   lights_q, lights_d;
    logic [N_APPR-1:0]     active_onehot;
    logic                  others;

    // First requester after cur, wrapping; cur itself has the lowest precedence.
    function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] cur,
                                              input logic [N_APPR-1:0] r);
        int idx;
        rr_pick = cur;
        for (int k = N_APPR; k >= 1; k--) begin
            idx = (int'(cur) + k) % N_APPR;
            if (r[idx[IW-1:0]]) rr_pick = idx[IW-1:0];
        end
    endfunction

    function automatic logic [2*N_APPR-1:0] lamp_code(input phase_t ph,
                                                      input logic [IW-1:0] idx);
        logic [1:0] code;
        lamp_code = '0;
        case (ph)
            GREEN:   code = 2'b10;
            YELLOW:  code = 2'b01;
            default: code = 2'b00;
        endcase
        for (int i = 0; i < N_APPR; i++) begin
            if (i[IW-1:0] == idx) lamp_code[2*i +: 2] = code;
        end
    endfunction

    assign active_onehot = N_APPR'(1) << active_q;
    assign others        = |(req & ~active_onehot);

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        grant_d   = 1'b0;
        timer_inc = (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;
        case (state_q)
            ALLRED: begin
                if (timer_q >= AR_LAST) begin
`ifdef PREEMPT_EN
                    if (preempt) begin
                        active_d = preempt_idx;
                        state_d  = GREEN;
                        grant_d  = 1'b1;
                    end else
`endif
                    if (|req) begin
                        active_d = rr_pick(active_q, req);
                        state_d  = GREEN;
                        grant_d  = 1'b1;
                    end
                end
            end
            GREEN: begin
`ifdef PREEMPT_EN
                if (preempt) begin
                    if (active_q != preempt_idx) state_d = YELLOW;
                end else
`endif
                if (timer_q >= GM_LAST && others &&
                    (!req[active_q] || timer_q >= GX_LAST))
                    state_d = YELLOW;
            end
            YELLOW: begin
                if (timer_q >= Y_LAST) state_d = ALLRED;
            end
            default: state_d = ALLRED;
        endcase
        timer_d  = (state_d != state_q) ? '0 : timer_inc;
        lights_d = lamp_code(state_d, active_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ALLRED;
            timer_q  <= '0;
            active_q <= IW'(N_APPR - 1);
            grant_q  <= 1'b0;
            lights_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            active_q <= active_d;
            grant_q  <= grant_d;
            lights_q <= lights_d;
        end
    end

    assign lights      = lights_q;
    assign active_idx  = active_q;
    assign phase       = state_q;
    assign grant_pulse = grant_q;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Bench for intersection_phase_arbiter: vector table, hand-written corner sequences and
// randomized requests checked against a phase/count reference model.
module tb_intersection_phase_arbiter;

    localparam int N = 4, AR = 2, GMIN = 4, GMAX = 12, YT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [7:0] lights;
    logic [1:0] active_idx;
    logic [1:0] phase;
    logic       grant_pulse;
`ifdef PREEMPT_EN
    logic       preempt = 1'b0;
    logic [1:0] preempt_idx = 2'd0;
`endif

    intersection_phase_arbiter #(
        .N_APPR(N), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
        .YELLOW_T(YT), .ALLRED_T(AR), .TW(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
`ifdef PREEMPT_EN
        .preempt(preempt),
        .preempt_idx(preempt_idx),
`endif
        .lights(lights),
        .active_idx(active_idx),
        .phase(phase),
        .grant_pulse(grant_pulse)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: phase (0 red,1 green,2 yellow), cycles spent in it, holder, grant flag
    int m_ph, m_cnt, m_act;
    int m_grant;

    typedef struct {
        logic [3:0] rq;
        int         n;
        logic [7:0] lt;
        logic [1:0] ph;
        logic [1:0] act;
        logic       gp;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int pick_next(input int cur, input logic [3:0] r);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (cur + k) % N;
            if (r[c[1:0]]) return c;
        end
        return cur;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_cnt = 0; m_act = N - 1; m_grant = 0;
    endtask

    task automatic model_step();
        bit p;
        int pi;
        bit others;
        p = 0; pi = 0;
`ifdef PREEMPT_EN
        p = preempt; pi = int'(preempt_idx);
`endif
        others = (req & ~(4'b0001 << m_act)) != 4'b0000;
        m_grant = 0;
        if (m_ph == 0) begin
            if (m_cnt >= AR - 1 && (p || req != 4'b0000)) begin
                m_act = p ? pi : pick_next(m_act, req);
                m_ph = 1; m_cnt = 0; m_grant = 1;
            end else m_cnt++;
        end else if (m_ph == 1) begin
            if (p ? (m_act != pi)
                  : (m_cnt >= GMIN - 1 && others && (!req[m_act] || m_cnt >= GMAX - 1))) begin
                m_ph = 2; m_cnt = 0;
            end else m_cnt++;
        end else begin
            if (m_cnt >= YT - 1) begin m_ph = 0; m_cnt = 0; end
            else m_cnt++;
        end
    endtask

    function automatic logic [7:0] m_lights();
        if (m_ph == 0) return 8'h00;
        return 8'((m_ph == 1 ? 2 : 1) << (2 * m_act));
    endfunction

    task automatic compare_all();
        int nr;
        nr = 0;
        chk("lights", lights, m_lights());
        chk("phase", phase, m_ph);
        chk("active_idx", active_idx, m_act);
        chk("grant_pulse", grant_pulse, m_grant);
        for (int i = 0; i < N; i++) if (lights[2*i +: 2] != 2'b00) nr++;
        chk("one_lamp", int'(nr <= 1), 1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        compare_all();
    endtask

    // Called one unit after an edge; asserts reset between edges and releases it likewise
    task automatic reset_pulse();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        chk("rst_lights_async", lights, 0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int bound);
        int n;
        n = 0;
        do begin tick(); n++; end while (!grant_pulse && n < bound);
        chk("grant_seen", grant_pulse, 1);
    endtask

    task automatic green_len(input int drop_cycle, input int exp_len);
        int gl, n;
        reset_pulse();
        req = 4'b0011;
        wait_grant(10);
        chk("first_holder", active_idx, 0);
        gl = 1;
        repeat (drop_cycle - 1) begin tick(); if (phase == 2'b01) gl++; end
        req = 4'b0010;
        n = 0;
        while (phase == 2'b01 && n < 40) begin tick(); n++; if (phase == 2'b01) gl++; end
        chk("green_len", gl, exp_len);
        wait_grant(10);
        chk("next_holder", active_idx, 1);
    endtask

    initial begin
        int gcount, ng, cyc;
        int g_act[5];
        int g_cyc[5];

        tbl[0] = '{4'b0101,  1, 8'h00, 2'b00, 2'd3, 1'b0};
        tbl[1] = '{4'b0101,  1, 8'h02, 2'b01, 2'd0, 1'b1};
        tbl[2] = '{4'b0101, 11, 8'h02, 2'b01, 2'd0, 1'b0};
        tbl[3] = '{4'b0101,  3, 8'h01, 2'b10, 2'd0, 1'b0};
        tbl[4] = '{4'b0101,  2, 8'h00, 2'b00, 2'd0, 1'b0};
        tbl[5] = '{4'b0101,  1, 8'h20, 2'b01, 2'd2, 1'b1};
        tbl[6] = '{4'b0101, 11, 8'h20, 2'b01, 2'd2, 1'b0};
        tbl[7] = '{4'b0101,  3, 8'h10, 2'b10, 2'd2, 1'b0};
        tbl[8] = '{4'b0101,  2, 8'h00, 2'b00, 2'd2, 1'b0};
        tbl[9] = '{4'b0101,  1, 8'h02, 2'b01, 2'd0, 1'b1};

        #1;
        reset_pulse();
        chk("reset_active", active_idx, 3);

        // Alternation between approaches 0 and 2 under constant requests
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].rq;
            for (int j = 0; j < tbl[i].n; j++) begin
                tick();
                chk("tbl_lights", lights, tbl[i].lt);
                chk("tbl_phase", phase, tbl[i].ph);
                chk("tbl_active", active_idx, tbl[i].act);
                chk("tbl_grant", grant_pulse, tbl[i].gp);
            end
        end

        // Reset mid-green, then rest on red with no requests
        reset_pulse();
        req = 4'b0001;
        wait_grant(10);
        tick(); tick();
        req = 4'b0000;
        reset_pulse();
        gcount = 0;
        repeat (40) begin tick(); if (grant_pulse) gcount++; end
        chk("idle_no_grant", gcount, 0);
        chk("idle_phase", phase, 0);

        // Single requester: two cycles of red, then rest on green
        reset_pulse();
        req = 4'b0001;
        tick();
        chk("solo_red1", phase, 0);
        tick();
        chk("solo_green", lights, 8'h02);
        chk("solo_grant", grant_pulse, 1);
        repeat (55) tick();
        chk("solo_hold", lights, 8'h02);

        // Own request dropped early (min green) and late
        green_len(2, 4);
        green_len(7, 7);

        // All four requesting: strict round-robin, 17 cycles per grant
        reset_pulse();
        req = 4'hF;
        ng = 0; cyc = 0;
        while (ng < 5 && cyc < 400) begin
            tick(); cyc++;
            if (grant_pulse) begin g_act[ng] = active_idx; g_cyc[ng] = cyc; ng++; end
        end
        chk("rr_grants", ng, 5);
        if (ng == 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", g_act[k], k % 4);
            chk("rr_period", g_cyc[4] - g_cyc[0], 68);
        end

`ifdef PREEMPT_EN
        reset_pulse();
        req = 4'b0010;
        wait_grant(10);
        chk("pre_holder", active_idx, 1);
        req = 4'b0011;
        tick();
        preempt = 1'b1;
        preempt_idx = 2'd3;
        tick();
        chk("pre_yellow", phase, 2);
        repeat (4) tick();
        chk("pre_allred", phase, 0);
        tick();
        chk("pre_green", lights, 8'h80);
        chk("pre_active", active_idx, 3);
        repeat (30) tick();
        chk("pre_hold", lights, 8'h80);
        preempt = 1'b0;
        tick();
        chk("pre_release", phase, 2);
`endif

        // Randomized requests (and occasional resets) against the model
        reset_pulse();
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
`ifdef PREEMPT_EN
            if ($urandom_range(0, 119) == 0) begin
                preempt = ~preempt;
                preempt_idx = 2'($urandom_range(0, 3));
            end
`endif
            if ($urandom_range(0, 799) == 0) reset_pulse();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
